// File: rtl/booth_mult_rr_sched_if.sv
// Request/response bundle for the shared Booth multiplier.
// master = clients and the product consumer, slave = the multiplier.
interface booth_mult_rr_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_m;
    logic [N_REQ*WIDTH-1:0] req_q;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [2*WIDTH-1:0]     rsp_p;
    logic                   busy;

    modport master (
        output req_valid, req_m, req_q, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p, busy
    );

    modport slave (
        input  req_valid, req_m, req_q, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p, busy
    );
endinterface

// File: rtl/booth_mult_rr_sched.sv
// One radix-2 Booth multiplier (one step per clock) shared by N_REQ requesters
// through a round-robin arbiter; the product is returned tagged with the requester id.
module booth_mult_rr_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    booth_mult_rr_sched_if.slave  bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   r_state;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [WIDTH:0]    r_a;
    logic signed [WIDTH:0]    r_m;
    logic [WIDTH-1:0]         r_q;
    logic                     r_qm1;
    logic [ID_W-1:0]          r_id;
    logic [ID_W-1:0]          r_ptr;
    logic [2*WIDTH-1:0]       r_p;
    logic                     r_rsp_valid;

    logic [N_REQ-1:0]         w_grant;
    logic [ID_W-1:0]          w_gnt_id;
    logic                     w_found;
    int unsigned              w_idx;
    logic [WIDTH-1:0]         w_m_sel;
    logic [WIDTH-1:0]         w_q_sel;
    logic signed [WIDTH:0]    w_sum;
    logic signed [WIDTH:0]    w_a_nxt;
    logic [WIDTH-1:0]         w_q_nxt;

    // Search starts just after the last winner, so every waiting requester
    // is reached within N_REQ grants.
    always_comb begin
        w_grant  = '0;
        w_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            w_idx = (32'(r_ptr) + k) % N_REQ;
            if (!w_found && bus.req_valid[ID_W'(w_idx)]) begin
                w_found                 = 1'b1;
                w_gnt_id                = ID_W'(w_idx);
                w_grant[ID_W'(w_idx)]   = 1'b1;
            end
        end
        if (r_state != S_IDLE || !rst_n) begin
            w_grant = '0;
            w_found = 1'b0;
        end
    end

    assign w_m_sel = bus.req_m[32'(w_gnt_id)*WIDTH +: WIDTH];
    assign w_q_sel = bus.req_q[32'(w_gnt_id)*WIDTH +: WIDTH];

    always_comb begin
        w_sum = r_a;
        case ({r_q[0], r_qm1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
        w_a_nxt = {w_sum[WIDTH], w_sum[WIDTH:1]};
        w_q_nxt = {w_sum[0], r_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_m         <= '0;
            r_q         <= '0;
            r_qm1       <= 1'b0;
            r_id        <= '0;
            r_ptr       <= ID_W'(N_REQ - 1);
            r_p         <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_a     <= '0;
                        r_m     <= {w_m_sel[WIDTH-1], w_m_sel};
                        r_q     <= w_q_sel;
                        r_qm1   <= 1'b0;
                        r_id    <= w_gnt_id;
                        r_ptr   <= w_gnt_id;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a   <= w_a_nxt;
                    r_q   <= w_q_nxt;
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Final step: {A,Q} holds the product sign-extended by one bit.
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_p         <= {w_a_nxt[WIDTH-1:0], w_q_nxt};
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_p     = r_p;
    assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_booth_mult_rr_sched.sv
// Bench for booth_mult_rr_sched: directed cases plus random traffic checked
// against a latency/round-robin/product reference model.
module tb_booth_mult_rr_sched;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    booth_mult_rr_sched_if #(.N_REQ(N), .WIDTH(W)) bus ();

    booth_mult_rr_sched #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 1; k <= N; k++) begin
            int i = (ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int pr;
        pr = int'($signed(a)) * int'($signed(b));
        return pr[2*W-1:0];
    endfunction

    // Reference model state, owned by the monitor.
    bit              m_busy = 1'b0;
    int              m_ptr = N - 1;
    int              m_acc_cyc = 0;
    int              m_id = 0;
    logic [2*W-1:0]  m_p = '0;
    int              n_acc = 0;
    int              n_rsp = 0;
    int              acc_ids[$];
    int              acc_cycs[$];
    int              mg;
    bit              mrv;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_req_ready", 32'(bus.req_ready), 32'(0));
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
            check("rst_rsp_id",    32'(bus.rsp_id),    32'(0));
            check("rst_rsp_p",     32'(bus.rsp_p),     32'(0));
            check("rst_busy",      32'(bus.busy),      32'(0));
            if (m_busy) n_acc--;
            m_busy = 1'b0;
            m_ptr  = N - 1;
        end else if (!m_busy) begin
            mg = rr_pick(bus.req_valid, m_ptr);
            check("req_ready", 32'(bus.req_ready), (mg >= 0) ? (32'(1) << mg) : 32'(0));
            check("idle_rsp_valid", 32'(bus.rsp_valid), 32'(0));
            check("idle_busy", 32'(bus.busy), 32'(0));
            if (mg >= 0) begin
                m_busy    = 1'b1;
                m_acc_cyc = cyc;
                m_id      = mg;
                m_p       = ref_mul(bus.req_m[mg*W +: W], bus.req_q[mg*W +: W]);
                m_ptr     = mg;
                acc_ids.push_back(mg);
                acc_cycs.push_back(cyc);
                n_acc++;
            end
        end else begin
            check("busy_req_ready", 32'(bus.req_ready), 32'(0));
            check("busy_busy", 32'(bus.busy), 32'(1));
            mrv = (cyc - m_acc_cyc) >= (W + 1);
            check("rsp_valid", 32'(bus.rsp_valid), 32'(mrv));
            if (mrv) begin
                check("rsp_p", 32'(bus.rsp_p), 32'(m_p));
                check("rsp_id", 32'(bus.rsp_id), 32'(m_id));
                if (bus.rsp_ready) begin
                    m_busy = 1'b0;
                    n_rsp++;
                end
            end
        end
    end

    bit keep = 1'b0;
    bit rnd_mode = 1'b0;

    function automatic logic [W-1:0] pick_op();
        case ($urandom_range(0, 7))
            0:       return {1'b1, {(W-1){1'b0}}};
            1:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    task automatic new_ops(input int i);
        bus.req_m[i*W +: W] = pick_op();
        bus.req_q[i*W +: W] = pick_op();
    endtask

    // One clock: note the grants of this cycle, then update requesters after the edge.
    task automatic tick();
        logic [N-1:0] g;
        @(negedge clk);
        g = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (g[i]) begin
                if (keep) new_ops(i);
                else bus.req_valid[i] = 1'b0;
            end else if (rnd_mode) begin
                if (!bus.req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        new_ops(i);
                        bus.req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
        if (rnd_mode) bus.rsp_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        rnd_mode = 1'b0;
        keep = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (!m_busy) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_timeout", 32'(done), 32'(1));
    endtask

    task automatic one_op(input int idx, input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [2*W-1:0] exp_p);
        int lat;
        lat = -1;
        bus.req_m[idx*W +: W] = m;
        bus.req_q[idx*W +: W] = q;
        bus.req_valid[idx] = 1'b1;
        bus.rsp_ready = 1'b1;
        #3;
        check("grant_onehot", 32'(bus.req_ready), 32'(1) << idx);
        for (int k = 1; k <= 40; k++) begin
            tick();
            #3;
            if (bus.rsp_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'(W + 1));
        check("prod", 32'(bus.rsp_p), 32'(exp_p));
        check("prod_id", 32'(bus.rsp_id), 32'(idx));
        tick();
    endtask

    initial begin
        int base;
        int lat;
        bit ok;
        bus.req_valid = '0;
        bus.req_m = '0;
        bus.req_q = '0;
        bus.rsp_ready = 1'b0;
        #2;
        do_reset();

        one_op(0, 8'd7, 8'hFD, 16'hFFEB);
        one_op(0, 8'h80, 8'h80, 16'h4000);
        one_op(0, 8'h80, 8'h7F, 16'hC080);
        drain();

        // Round-robin order with every requester continuously asking.
        do_reset();
        keep = 1'b1;
        for (int i = 0; i < N; i++) new_ops(i);
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        base = acc_ids.size();
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (acc_ids.size() >= base + 5) begin
                ok = 1'b1;
                break;
            end
        end
        check("rr_timeout", 32'(ok), 32'(1));
        if (ok) begin
            for (int j = 0; j < 5; j++) begin
                check("rr_order", 32'(acc_ids[base + j]), 32'(j % N));
                if (j > 0) check("rr_interval", 32'(acc_cycs[base + j] - acc_cycs[base + j - 1]), 32'(W + 2));
            end
        end
        drain();

        // Consumer stall in DONE.
        bus.req_m[1*W +: W] = 8'h55;
        bus.req_q[1*W +: W] = 8'hAA;
        bus.req_valid[1] = 1'b1;
        bus.rsp_ready = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            #3;
            if (bus.rsp_valid) begin
                lat = k;
                break;
            end
        end
        check("stall_latency", 32'(lat), 32'(W + 1));
        for (int k = 0; k < 20; k++) begin
            tick();
            #3;
            check("stall_valid", 32'(bus.rsp_valid), 32'(1));
            check("stall_p", 32'(bus.rsp_p), 32'(ref_mul(8'h55, 8'hAA)));
            check("stall_id", 32'(bus.rsp_id), 32'(1));
            check("stall_req_ready", 32'(bus.req_ready), 32'(0));
        end
        bus.rsp_ready = 1'b1;
        tick();
        #3;
        check("stall_release_busy", 32'(bus.busy), 32'(0));
        drain();

        // Reset in RUN at count==4 discards the op; priority restarts at index 0.
        bus.req_m[2*W +: W] = 8'h33;
        bus.req_q[2*W +: W] = 8'h11;
        bus.req_valid[2] = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'(0));
        check("abort_rsp_p", 32'(bus.rsp_p), 32'(0));
        check("abort_rsp_id", 32'(bus.rsp_id), 32'(0));
        check("abort_req_ready", 32'(bus.req_ready), 32'(0));
        tick();
        rst_n = 1'b1;
        new_ops(0);
        new_ops(1);
        bus.req_valid = 4'b0011;
        #3;
        check("post_abort_grant", 32'(bus.req_ready), 32'(1));
        drain();

        // Random traffic with consumer stalls.
        rnd_mode = 1'b1;
        base = n_rsp + 1000;
        ok = 1'b0;
        for (int k = 0; k < 40000; k++) begin
            tick();
            if (n_rsp >= base) begin
                ok = 1'b1;
                break;
            end
        end
        check("random_timeout", 32'(ok), 32'(1));
        drain();
        check("acc_vs_rsp", 32'(n_acc), 32'(n_rsp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
